// File: rtl/decoder_scan_n_pkg.sv
// Shared definitions for the scanning N-to-2^N decoder: mode encoding and FSM state type.
package decoder_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2,
      BLANK  = 2'd3
   } dec_state_t;

endpackage

// File: rtl/decoder_scan_n_if.sv
// Control/strobe bundle for decoder_scan_n. The master drives enable, mode and select;
// the slave (the decoder) returns the strobes and scan status.
interface decoder_scan_n_if #(
   parameter int SEL_W = 3
);
   logic                  en_n;
   logic                  mode;
   logic [SEL_W-1:0]      sel;
   logic                  sel_valid;
   logic [(2**SEL_W)-1:0] y_n;
   logic [SEL_W-1:0]      cur_idx;
   logic                  scan_wrap;
   logic                  busy;

   modport master (
      output en_n, mode, sel, sel_valid,
      input  y_n, cur_idx, scan_wrap, busy
   );

   modport slave (
      input  en_n, mode, sel, sel_valid,
      output y_n, cur_idx, scan_wrap, busy
   );
endinterface

// File: rtl/decoder_scan_n_onehot.sv
// Combinational index to active-low one-hot map.
module onehot_dec_n #(
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0]      idx,
   output logic [(2**SEL_W)-1:0] y_n
);

   // Drive every line inactive, then pull the selected one low.
   always_comb begin
      y_n      = '1;
      y_n[idx] = 1'b0;
   end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N active-low decoder with DIRECT and SCAN modes.
// Optional build macro DECODER_SCAN_BLANK_EN inserts one all-inactive BLANK cycle
// after every dwell (anti-ghosting for multiplexed displays).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | disabled, all strobes inactive, cur_idx and sel_q held
// DIRECT | strobe follows captured select sel_q
// SCAN   | strobe walks 0..OUT_N-1, each index held for DWELL cycles
// BLANK  | one all-inactive cycle between scan indices (macro builds only)
module decoder_scan_n
   import decoder_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int DWELL = 4
) (
   input logic              clk,
   input logic              rst,
   decoder_scan_n_if.slave  bus
);

   localparam int OUT_N   = 2**SEL_W;
   localparam int DWELL_W = $clog2(DWELL + 1);
   localparam logic [DWELL_W-1:0] CNT_LOAD = DWELL_W'(DWELL - 1);
   localparam logic [SEL_W-1:0]   IDX_LAST = SEL_W'(OUT_N - 1);

   dec_state_t         state_q, state_nx;
   logic [SEL_W-1:0]   sel_q, sel_nx;
   logic [SEL_W-1:0]   idx_q, idx_nx;
   logic [DWELL_W-1:0] cnt_q, cnt_nx;
   logic               wrap_nx;
   logic               wrap_q, busy_q;
   logic [OUT_N-1:0]   dec_y_n, y_q;

   // Next-state, next index and dwell countdown; en_n beats mode, scan entry restarts at 0.
   always_comb begin
      state_nx = state_q;
      sel_nx   = sel_q;
      idx_nx   = idx_q;
      cnt_nx   = cnt_q;
      wrap_nx  = 1'b0;
      if (bus.en_n) begin
         state_nx = IDLE;
      end else if (bus.mode == MODE_DIRECT) begin
         state_nx = DIRECT;
         if (bus.sel_valid) begin
            sel_nx = bus.sel;
         end
         idx_nx = sel_nx;
      end else begin
         case (state_q)
            SCAN: begin
               if (cnt_q != '0) begin
                  cnt_nx = cnt_q - DWELL_W'(1);
               end else begin
`ifdef DECODER_SCAN_BLANK_EN
                  state_nx = BLANK;
`else
                  idx_nx   = idx_q + SEL_W'(1);
                  cnt_nx   = CNT_LOAD;
                  wrap_nx  = (idx_q == IDX_LAST);
`endif
               end
            end
`ifdef DECODER_SCAN_BLANK_EN
            BLANK: begin
               state_nx = SCAN;
               idx_nx   = idx_q + SEL_W'(1);
               cnt_nx   = CNT_LOAD;
               wrap_nx  = (idx_q == IDX_LAST);
            end
`endif
            default: begin
               state_nx = SCAN;
               idx_nx   = '0;
               cnt_nx   = CNT_LOAD;
            end
         endcase
      end
   end

   onehot_dec_n #(.SEL_W(SEL_W)) u_dec (
      .idx (idx_nx),
      .y_n (dec_y_n)
   );

   // Output and state registers; strobe is only driven in DIRECT and SCAN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         y_q     <= '1;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_nx;
         sel_q   <= sel_nx;
         idx_q   <= idx_nx;
         cnt_q   <= cnt_nx;
         y_q     <= (state_nx == DIRECT || state_nx == SCAN) ? dec_y_n : '1;
         wrap_q  <= wrap_nx;
         busy_q  <= (state_nx == SCAN || state_nx == BLANK);
      end
   end

   assign bus.y_n       = y_q;
   assign bus.cur_idx   = idx_q;
   assign bus.scan_wrap = wrap_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Bench for decoder_scan_n: two instances (DWELL=4 and DWELL=1) share one stimulus stream
// and are compared every cycle against an elapsed-time model of the scan.
module tb_decoder_scan_n;

`ifdef DECODER_SCAN_BLANK_EN
   localparam int BLK = 1;
`else
   localparam int BLK = 0;
`endif
   localparam int P4 = 4 + BLK;

   logic clk = 1'b0;
   logic rst = 1'b1;

   decoder_scan_n_if #(.SEL_W(3)) bus4 ();
   decoder_scan_n_if #(.SEL_W(3)) bus1 ();

   decoder_scan_n #(.SEL_W(3), .DWELL(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   decoder_scan_n #(.SEL_W(3), .DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // model: st 0=idle 1=direct 2=scanning; pos = cycles since scan entry
   int m_st[2], m_sel[2], m_last[2], m_pos[2];
   int dw[2] = '{4, 1};

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic step(input bit r, input bit e, input bit m, input int s, input bit v);
      int ey, ei, ew, eb, p, idx;
      int ay, ai, aw, ab;
      rst = r;
      bus4.en_n = e; bus4.mode = m; bus4.sel = 3'(s); bus4.sel_valid = v;
      bus1.en_n = e; bus1.mode = m; bus1.sel = 3'(s); bus1.sel_valid = v;
      for (int k = 0; k < 2; k++) begin
         p = dw[k] + BLK;
         if (r) begin
            m_st[k] = 0; m_sel[k] = 0; m_last[k] = 0; m_pos[k] = 0;
         end else if (e) begin
            m_st[k] = 0;
         end else if (!m) begin
            m_st[k] = 1;
            if (v) m_sel[k] = s;
            m_last[k] = m_sel[k];
         end else begin
            m_pos[k] = (m_st[k] == 2) ? m_pos[k] + 1 : 0;
            m_st[k]  = 2;
            m_last[k] = (m_pos[k] / p) % 8;
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         p = dw[k] + BLK;
         ew = 0; eb = 0; ey = 'hFF; ei = m_last[k];
         if (m_st[k] == 1) begin
            ey = 'hFF & ~(1 << m_sel[k]);
         end else if (m_st[k] == 2) begin
            idx = (m_pos[k] / p) % 8;
            ey  = (BLK == 1 && (m_pos[k] % p) == dw[k]) ? 'hFF : ('hFF & ~(1 << idx));
            ew  = (m_pos[k] != 0 && (m_pos[k] % (8 * p)) == 0) ? 1 : 0;
            eb  = 1;
         end
         ay = (k == 0) ? int'(bus4.y_n)      : int'(bus1.y_n);
         ai = (k == 0) ? int'(bus4.cur_idx)  : int'(bus1.cur_idx);
         aw = (k == 0) ? int'(bus4.scan_wrap): int'(bus1.scan_wrap);
         ab = (k == 0) ? int'(bus4.busy)     : int'(bus1.busy);
         check($sformatf("model_y_n[d%0d]", dw[k]), ay, ey);
         check($sformatf("model_cur_idx[d%0d]", dw[k]), ai, ei);
         check($sformatf("model_wrap[d%0d]", dw[k]), aw, ew);
         check($sformatf("model_busy[d%0d]", dw[k]), ab, eb);
      end
   endtask

   typedef struct {
      bit r, e, m;
      int s;
      bit v;
      int y, idx, busy;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w4, w1, mode_r;
      bit  r, e, v;

      bus4.en_n = 1'b0; bus4.mode = 1'b1; bus4.sel = '0; bus4.sel_valid = 1'b0;
      bus1.en_n = 1'b0; bus1.mode = 1'b1; bus1.sel = '0; bus1.sel_valid = 1'b0;

      //          r  e  m  sel v  y_n    idx busy
      tbl[0]  = '{1, 0, 1, 0,  0, 'hFF,  0,  0};
      tbl[1]  = '{1, 0, 1, 0,  0, 'hFF,  0,  0};
      tbl[2]  = '{0, 0, 0, 5,  1, 'hDF,  5,  0};
      tbl[3]  = '{0, 0, 0, 2,  0, 'hDF,  5,  0};
      tbl[4]  = '{0, 0, 0, 2,  0, 'hDF,  5,  0};
      tbl[5]  = '{0, 0, 0, 0,  1, 'hFE,  0,  0};
      tbl[6]  = '{0, 1, 0, 3,  1, 'hFF,  0,  0};
      tbl[7]  = '{0, 0, 0, 3,  0, 'hFE,  0,  0};
      tbl[8]  = '{0, 0, 0, 7,  1, 'h7F,  7,  0};
      tbl[9]  = '{0, 1, 0, 1,  0, 'hFF,  7,  0};
      tbl[10] = '{0, 0, 0, 1,  0, 'h7F,  7,  0};
      tbl[11] = '{0, 1, 1, 4,  1, 'hFF,  7,  0};
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].v);
         check($sformatf("tbl%0d_y_n", i), int'(bus4.y_n), tbl[i].y);
         check($sformatf("tbl%0d_cur_idx", i), int'(bus4.cur_idx), tbl[i].idx);
         check($sformatf("tbl%0d_busy", i), int'(bus4.busy), tbl[i].busy);
      end

      // reset with scan requested, then first strobe right after release
      step(1, 0, 1, 0, 0);
      check("rst_y_n", int'(bus4.y_n), 'hFF);
      step(0, 0, 1, 0, 0);
      check("scan_first_y4", int'(bus4.y_n), 'hFE);
      check("scan_first_y1", int'(bus1.y_n), 'hFE);
      check("scan_first_wrap", int'(bus4.scan_wrap), 0);
      w4 = -1; w1 = -1;
      for (int c = 1; c <= 45; c++) begin
         step(0, 0, 1, 0, 0);
         if (bus4.scan_wrap && w4 < 0) w4 = c;
         if (bus1.scan_wrap && w1 < 0) w1 = c;
         if (c == 3) check("scan_hold_fe", int'(bus4.y_n), 'hFE);
         if (c == 4) check("scan_pos4", int'(bus4.y_n), (BLK == 1) ? 'hFF : 'hFD);
         if (c == 5) check("scan_pos5", int'(bus4.y_n), 'hFD);
         if (c == 1) check("dwell1_pos1", int'(bus1.y_n), (BLK == 1) ? 'hFF : 'hFD);
      end
      check("wrap_cycle_d4", w4, 8 * P4);
      check("wrap_cycle_d1", w1, 8 * (1 + BLK));

      // enable drop at index 3 with two dwell cycles left
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      repeat (3 * P4 + 1) step(0, 0, 1, 0, 0);
      check("mid_idx3_y_n", int'(bus4.y_n), 'hF7);
      check("mid_idx3_cur", int'(bus4.cur_idx), 3);
      step(0, 1, 1, 0, 0);
      check("en_off_y_n", int'(bus4.y_n), 'hFF);
      check("en_off_busy", int'(bus4.busy), 0);
      step(0, 0, 1, 0, 0);
      check("restart_y_n", int'(bus4.y_n), 'hFE);
      repeat (3) step(0, 0, 1, 0, 0);
      check("restart_dwell_end", int'(bus4.y_n), 'hFE);
      step(0, 0, 1, 0, 0);
      check("restart_next", int'(bus4.y_n), (BLK == 1) ? 'hFF : 'hFD);

      // simultaneous en_n and mode change; DIRECT->SCAN ignores sel
      step(0, 1, 0, 0, 0);
      check("en_mode_y_n", int'(bus4.y_n), 'hFF);
      check("en_mode_busy", int'(bus4.busy), 0);
      step(0, 0, 0, 6, 1);
      check("direct6_y_n", int'(bus4.y_n), 'hBF);
      step(0, 0, 1, 2, 1);
      check("d2s_y_n", int'(bus4.y_n), 'hFE);
      check("d2s_cur_idx", int'(bus4.cur_idx), 0);
      check("d2s_busy", int'(bus4.busy), 1);

      // randomized traffic against the model
      mode_r = 1;
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         e = ($urandom_range(0, 15) == 0);
         v = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 39) == 0) mode_r = 1 - mode_r;
         step(r, e, (mode_r == 1), $urandom_range(0, 7), v);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
